// File: rtl/multi_paddle_engine_if.sv
// Signal bundle between the input/frame-rate logic, multi_paddle_engine and the paddle renderer.
// The engine uses the slave view; whoever drives buttons, ticks and acks uses the master view.
interface multi_paddle_engine_if #(
  parameter int NUM_PADDLES = 2,
  parameter int Y_W         = 9
);
  localparam int IDX_W = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;

  logic                       enable;
  logic                       frame_tick;
  logic [NUM_PADDLES-1:0]     up;
  logic [NUM_PADDLES-1:0]     down;
  logic [NUM_PADDLES*Y_W-1:0] paddle_y;
  logic [NUM_PADDLES*Y_W-1:0] old_paddle_y;
  logic [NUM_PADDLES-1:0]     moved;
  logic                       upd_req;
  logic [IDX_W-1:0]           upd_idx;
  logic                       upd_ack;
  logic                       busy;
  logic                       overrun;

  modport slave (
    input  enable, frame_tick, up, down, upd_ack,
    output paddle_y, old_paddle_y, moved, upd_req, upd_idx, busy, overrun
  );

  modport master (
    output enable, frame_tick, up, down, upd_ack,
    input  paddle_y, old_paddle_y, moved, upd_req, upd_idx, busy, overrun
  );
endinterface

// File: rtl/multi_paddle_engine.sv
// NUM_PADDLES clamped paddle positions stepped once per frame tick, optionally accelerating,
// followed by an in-order req/ack render request for every paddle that moved.
module multi_paddle_engine #(
  parameter int NUM_PADDLES = 2,
  parameter int Y_W         = 9,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 480,
  parameter int PADDLE_H    = 40,
  parameter int Y_INIT      = 220,
  parameter int RATE        = 1,
  parameter int MAX_RATE    = 4,
  parameter int ACCEL       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_paddle_engine_if.slave bus
);
  localparam int IDX_W = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;
  localparam int YX_W  = Y_W + 1;
  localparam int SPD_W = (MAX_RATE > 1) ? $clog2(MAX_RATE + 1) : 1;

  localparam logic [YX_W-1:0]  Y_LO     = YX_W'(Y_MIN);
  localparam logic [YX_W-1:0]  Y_HI     = YX_W'(Y_MAX - PADDLE_H);
  localparam logic [SPD_W-1:0] SPD_BASE = SPD_W'(RATE);
  localparam logic [SPD_W-1:0] SPD_TOP  = SPD_W'(MAX_RATE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PADDLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REQ} state_t;
  typedef enum logic [1:0] {D_STOP, D_UP, D_DOWN} dir_t;

  state_t                          r_state, w_state_nxt;
  logic [IDX_W-1:0]                r_scan_idx, w_scan_idx_nxt;
  logic                            r_upd_req, w_upd_req_nxt;
  logic                            r_busy, r_overrun;
  logic [NUM_PADDLES-1:0][Y_W-1:0] r_y, r_old_y, w_y_nxt;
  logic [NUM_PADDLES-1:0]          r_moved, w_moved_nxt;
  dir_t                            r_dir [NUM_PADDLES];
  dir_t                            w_dir [NUM_PADDLES];
  logic [SPD_W-1:0]                r_speed [NUM_PADDLES];
  logic [SPD_W-1:0]                w_speed_nxt [NUM_PADDLES];
  logic                            w_accept, w_overrun, w_last;

  assign w_accept  = bus.frame_tick && bus.enable && (r_state == S_IDLE);
  assign w_overrun = bus.frame_tick && bus.enable && (r_state != S_IDLE);
  assign w_last    = (r_scan_idx == IDX_LAST);

  // Arithmetic runs one bit wider than Y so neither y-step nor y+step can wrap.
  always_comb begin
    logic [YX_W-1:0] w_step, w_cur, w_sum, w_nxt;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
      w_dir[i] = D_STOP;
      if (bus.up[i] && !bus.down[i])      w_dir[i] = D_UP;
      else if (bus.down[i] && !bus.up[i]) w_dir[i] = D_DOWN;

      if (w_dir[i] == D_STOP || w_dir[i] != r_dir[i]) w_speed_nxt[i] = SPD_BASE;
      else if (r_speed[i] >= SPD_TOP)                 w_speed_nxt[i] = SPD_TOP;
      else                                            w_speed_nxt[i] = r_speed[i] + 1'b1;

      w_step = (ACCEL != 0) ? YX_W'(w_speed_nxt[i]) : YX_W'(RATE);
      w_cur  = {1'b0, r_y[i]};
      w_sum  = w_cur + w_step;
      w_nxt  = w_cur;
      case (w_dir[i])
        D_UP:    w_nxt = (w_cur < Y_LO + w_step) ? Y_LO : w_cur - w_step;
        D_DOWN:  w_nxt = (w_sum > Y_HI) ? Y_HI : w_sum;
        default: w_nxt = w_cur;
      endcase
      w_y_nxt[i]     = Y_W'(w_nxt);
      w_moved_nxt[i] = (w_nxt != w_cur);
    end
  end

  // Request sequencer: walk channels in index order, one SCAN cycle each, REQ until ack.
  always_comb begin
    w_state_nxt    = r_state;
    w_scan_idx_nxt = r_scan_idx;
    w_upd_req_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = S_SCAN;
          w_scan_idx_nxt = '0;
        end
      end
      S_SCAN: begin
        if (r_moved[r_scan_idx]) begin
          w_state_nxt   = S_REQ;
          w_upd_req_nxt = 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_scan_idx_nxt = r_scan_idx + 1'b1;
        end
      end
      S_REQ: begin
        if (bus.upd_ack) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt    = S_SCAN;
            w_scan_idx_nxt = r_scan_idx + 1'b1;
          end
        end else begin
          w_upd_req_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      r_state    <= S_IDLE;
      r_scan_idx <= '0;
      r_upd_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_moved    <= '0;
      // NOTE: the per-channel arrays are plain flops, not RAM, so they take the reset like any other state.
      for (int i = 0; i < NUM_PADDLES; i++) begin
        r_y[i]     <= Y_W'(Y_INIT);
        r_old_y[i] <= Y_W'(Y_INIT);
        r_speed[i] <= SPD_BASE;
        r_dir[i]   <= D_STOP;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_scan_idx <= w_scan_idx_nxt;
      r_upd_req  <= w_upd_req_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_overrun  <= w_overrun;
      if (w_accept) begin
        r_old_y <= r_y;
        r_y     <= w_y_nxt;
        r_moved <= w_moved_nxt;
        for (int i = 0; i < NUM_PADDLES; i++) begin
          r_speed[i] <= w_speed_nxt[i];
          r_dir[i]   <= w_dir[i];
        end
      end
    end
  end

  assign bus.paddle_y     = r_y;
  assign bus.old_paddle_y = r_old_y;
  assign bus.moved        = r_moved;
  assign bus.upd_req      = r_upd_req;
  assign bus.upd_idx      = r_scan_idx;
  assign bus.busy         = r_busy;
  assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_multi_paddle_engine.sv
// Bench for multi_paddle_engine: three parameterisations, a position model per instance and a
// request-index scoreboard for the main instance, whose renderer ack delay is programmable.
module tb_multi_paddle_engine;
  localparam int N  = 2;
  localparam int YW = 9;
  localparam int HI = 440;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multi_paddle_engine_if #(.NUM_PADDLES(N), .Y_W(YW)) a_if ();
  multi_paddle_engine_if #(.NUM_PADDLES(N), .Y_W(YW)) b_if ();
  multi_paddle_engine_if #(.NUM_PADDLES(N), .Y_W(YW)) c_if ();

  multi_paddle_engine #(.NUM_PADDLES(N), .Y_W(YW)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  multi_paddle_engine #(.NUM_PADDLES(N), .Y_W(YW), .Y_INIT(218), .RATE(4), .MAX_RATE(4)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));
  multi_paddle_engine #(.NUM_PADDLES(N), .Y_W(YW), .RATE(1), .MAX_RATE(4), .ACCEL(1)) dut_c (
    .clk(clk), .reset(reset), .bus(c_if.slave));

  // Instances b and c only exercise motion; their renderer acks in the first REQ cycle.
  assign b_if.upd_ack = b_if.upd_req;
  assign c_if.upd_ack = c_if.upd_req;

  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];
  int   ack_delay   = 0;
  int   wait_cnt    = 0;
  int   held_idx    = 0;
  int   req_count   = 0;
  int   busy_cycles = 0;
  logic req_prev    = 1'b0;
  int   ma_y[N], ma_old[N], mb_y[N], mc_y[N], mc_spd[N], mc_dir[N];

  function automatic int step_y(input int y, input logic u, input logic d, input int step);
    if (u && !d) return (y - step < 0) ? 0 : y - step;
    if (d && !u) return (y + step > HI) ? HI : y + step;
    return y;
  endfunction

  function automatic logic [N*YW-1:0] pack(input int v[N]);
    logic [N*YW-1:0] r;
    for (int i = 0; i < N; i++) r[i*YW +: YW] = YW'(v[i]);
    return r;
  endfunction

  // Renderer model + scoreboard for instance a: checks every new request against the queue,
  // checks the index is held while waiting, and acks after ack_delay extra cycles.
  always @(negedge clk) begin : renderer
    int e;
    if (a_if.busy) busy_cycles++;
    if (a_if.upd_req) begin
      if (!req_prev) begin
        req_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL req_unexpected: got idx %0d want no request", a_if.upd_idx);
        end else begin
          e = exp_q.pop_front();
          if (int'(a_if.upd_idx) !== e) begin
            bad++;
            $display("FAIL req_idx: got %0d want %0d", a_if.upd_idx, e);
          end
        end
        held_idx = int'(a_if.upd_idx);
        wait_cnt = 0;
      end else begin
        total++;
        if (int'(a_if.upd_idx) !== held_idx) begin
          bad++;
          $display("FAIL req_idx_stable: got %0d want %0d", a_if.upd_idx, held_idx);
        end
      end
      a_if.upd_ack = (wait_cnt == ack_delay);
      wait_cnt++;
    end else begin
      a_if.upd_ack = 1'b0;
    end
    req_prev = a_if.upd_req;
  end

  task automatic tick_a(input logic [N-1:0] u, input logic [N-1:0] d);
    logic [N-1:0] mv;
    int ny;
    a_if.up   = u;
    a_if.down = d;
    mv = '0;
    for (int i = 0; i < N; i++) begin
      ny        = step_y(ma_y[i], u[i], d[i], 1);
      mv[i]     = (ny != ma_y[i]);
      ma_old[i] = ma_y[i];
      ma_y[i]   = ny;
      if (mv[i]) exp_q.push_back(i);
    end
    busy_cycles = 0;
    a_if.frame_tick = 1'b1;
    @(negedge clk);
    a_if.frame_tick = 1'b0;
    total++;
    if (a_if.paddle_y !== pack(ma_y)) begin
      bad++; $display("FAIL a_paddle_y: got %h want %h", a_if.paddle_y, pack(ma_y));
    end
    total++;
    if (a_if.old_paddle_y !== pack(ma_old)) begin
      bad++; $display("FAIL a_old_paddle_y: got %h want %h", a_if.old_paddle_y, pack(ma_old));
    end
    total++;
    if (a_if.moved !== mv) begin
      bad++; $display("FAIL a_moved: got %b want %b", a_if.moved, mv);
    end
    total++;
    if (a_if.busy !== 1'b1) begin
      bad++; $display("FAIL a_busy_after_tick: got %b want 1", a_if.busy);
    end
  endtask

  task automatic wait_idle_a();
    for (int k = 0; k < 200 && a_if.busy !== 1'b0; k++) @(negedge clk);
    total++;
    if (a_if.busy !== 1'b0) begin
      bad++; $display("FAIL a_idle_timeout: got busy=%b want 0", a_if.busy);
    end
  endtask

  task automatic tick_b(input logic [N-1:0] u, input logic [N-1:0] d);
    logic [N-1:0] mv;
    int ny;
    b_if.up   = u;
    b_if.down = d;
    mv = '0;
    for (int i = 0; i < N; i++) begin
      ny      = step_y(mb_y[i], u[i], d[i], 4);
      mv[i]   = (ny != mb_y[i]);
      mb_y[i] = ny;
    end
    b_if.frame_tick = 1'b1;
    @(negedge clk);
    b_if.frame_tick = 1'b0;
    total++;
    if (b_if.paddle_y !== pack(mb_y) || b_if.moved !== mv) begin
      bad++;
      $display("FAIL b_clamp: got y=%h moved=%b want y=%h moved=%b", b_if.paddle_y, b_if.moved, pack(mb_y), mv);
    end
    for (int k = 0; k < 50 && b_if.busy !== 1'b0; k++) @(negedge clk);
    total++;
    if (b_if.busy !== 1'b0) begin
      bad++; $display("FAIL b_idle_timeout: got busy=%b want 0", b_if.busy);
    end
  endtask

  task automatic tick_c(input logic [N-1:0] u, input logic [N-1:0] d);
    int dir;
    c_if.up   = u;
    c_if.down = d;
    for (int i = 0; i < N; i++) begin
      dir = (u[i] && !d[i]) ? 1 : ((d[i] && !u[i]) ? 2 : 0);
      if (dir == 0 || dir != mc_dir[i]) mc_spd[i] = 1;
      else if (mc_spd[i] < 4)           mc_spd[i] = mc_spd[i] + 1;
      mc_dir[i] = dir;
      mc_y[i]   = step_y(mc_y[i], u[i], d[i], mc_spd[i]);
    end
    c_if.frame_tick = 1'b1;
    @(negedge clk);
    c_if.frame_tick = 1'b0;
    total++;
    if (c_if.paddle_y !== pack(mc_y)) begin
      bad++; $display("FAIL c_accel_y: got %h want %h", c_if.paddle_y, pack(mc_y));
    end
    for (int k = 0; k < 50 && c_if.busy !== 1'b0; k++) @(negedge clk);
    total++;
    if (c_if.busy !== 1'b0) begin
      bad++; $display("FAIL c_idle_timeout: got busy=%b want 0", c_if.busy);
    end
  endtask

  task automatic reset_models();
    for (int i = 0; i < N; i++) begin
      ma_y[i] = 220; ma_old[i] = 220; mb_y[i] = 218;
      mc_y[i] = 220; mc_spd[i] = 1;   mc_dir[i] = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    reset_models();
    total++;
    if (a_if.paddle_y !== pack(ma_y)) begin
      bad++; $display("FAIL reset_paddle_y: got %h want %h", a_if.paddle_y, pack(ma_y));
    end
    total++;
    if (a_if.old_paddle_y !== pack(ma_old)) begin
      bad++; $display("FAIL reset_old_y: got %h want %h", a_if.old_paddle_y, pack(ma_old));
    end
    total++;
    if ({a_if.moved, a_if.upd_req, a_if.upd_idx, a_if.busy, a_if.overrun} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got moved=%b req=%b idx=%0d busy=%b ovr=%b want all 0",
               a_if.moved, a_if.upd_req, a_if.upd_idx, a_if.busy, a_if.overrun);
    end
    total++;
    if (b_if.paddle_y !== pack(mb_y)) begin
      bad++; $display("FAIL reset_b_y: got %h want %h", b_if.paddle_y, pack(mb_y));
    end
  endtask

  task automatic test_single_up();
    int rc0;
    ack_delay = 0;
    rc0 = req_count;
    tick_a(2'b01, 2'b00);
    total++;
    if (a_if.upd_req !== 1'b0) begin
      bad++; $display("FAIL single_req_early: got %b want 0", a_if.upd_req);
    end
    @(negedge clk);
    total++;
    if (a_if.upd_req !== 1'b1 || a_if.upd_idx !== 1'b0) begin
      bad++; $display("FAIL single_req_t2: got req=%b idx=%0d want req=1 idx=0", a_if.upd_req, a_if.upd_idx);
    end
    wait_idle_a();
    total++;
    if (busy_cycles !== N + 1) begin
      bad++; $display("FAIL single_busy_len: got %0d want %0d", busy_cycles, N + 1);
    end
    total++;
    if (req_count - rc0 !== 1 || exp_q.size() !== 0) begin
      bad++; $display("FAIL single_req_count: got %0d left %0d want 1 left 0", req_count - rc0, exp_q.size());
    end
  endtask

  task automatic test_both_delay();
    int rc0;
    ack_delay = 5;
    rc0 = req_count;
    tick_a(2'b01, 2'b10);
    @(negedge clk);
    a_if.up = 2'b10;
    a_if.down = 2'b01;
    a_if.frame_tick = 1'b1;
    @(negedge clk);
    a_if.frame_tick = 1'b0;
    total++;
    if (a_if.overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_pulse: got %b want 1", a_if.overrun);
    end
    total++;
    if (a_if.paddle_y !== pack(ma_y)) begin
      bad++; $display("FAIL overrun_no_move: got %h want %h", a_if.paddle_y, pack(ma_y));
    end
    @(negedge clk);
    total++;
    if (a_if.overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_one_cycle: got %b want 0", a_if.overrun);
    end
    wait_idle_a();
    total++;
    if (busy_cycles !== N + 2 * 6) begin
      bad++; $display("FAIL both_busy_len: got %0d want %0d", busy_cycles, N + 2 * 6);
    end
    total++;
    if (req_count - rc0 !== 2 || exp_q.size() !== 0) begin
      bad++; $display("FAIL both_req_count: got %0d left %0d want 2 left 0", req_count - rc0, exp_q.size());
    end
    ack_delay = 0;
  endtask

  task automatic test_stop_and_disabled();
    int rc0;
    rc0 = req_count;
    tick_a(2'b11, 2'b11);
    wait_idle_a();
    total++;
    if (busy_cycles !== N || req_count !== rc0) begin
      bad++; $display("FAIL stop_busy_len: got %0d reqs %0d want %0d reqs 0", busy_cycles, req_count - rc0, N);
    end
    a_if.enable = 1'b0;
    a_if.up = 2'b01;
    a_if.down = 2'b00;
    busy_cycles = 0;
    a_if.frame_tick = 1'b1;
    @(negedge clk);
    a_if.frame_tick = 1'b0;
    total++;
    if (a_if.busy !== 1'b0 || a_if.overrun !== 1'b0 || a_if.moved !== 2'b00) begin
      bad++; $display("FAIL disabled_tick: got busy=%b ovr=%b moved=%b want 0 0 00", a_if.busy, a_if.overrun, a_if.moved);
    end
    total++;
    if (a_if.paddle_y !== pack(ma_y)) begin
      bad++; $display("FAIL disabled_no_move: got %h want %h", a_if.paddle_y, pack(ma_y));
    end
    @(negedge clk);
    total++;
    if (busy_cycles !== 0) begin
      bad++; $display("FAIL disabled_busy: got %0d want 0", busy_cycles);
    end
    a_if.enable = 1'b1;
  endtask

  task automatic test_clamp();
    for (int t = 0; t < 57; t++) tick_b(2'b01, 2'b10);
    total++;
    if (b_if.paddle_y !== {9'd440, 9'd0} || b_if.moved !== 2'b00) begin
      bad++; $display("FAIL clamp_final: got y=%h moved=%b want y=%h moved=00", b_if.paddle_y, b_if.moved, {9'd440, 9'd0});
    end
  endtask

  task automatic test_accel();
    for (int t = 0; t < 6; t++) tick_c(2'b00, 2'b01);
    total++;
    if (c_if.paddle_y !== {9'd220, 9'd238}) begin
      bad++; $display("FAIL accel_six_ticks: got %h want %h", c_if.paddle_y, {9'd220, 9'd238});
    end
    tick_c(2'b00, 2'b00);
    tick_c(2'b00, 2'b01);
    total++;
    if (c_if.paddle_y !== {9'd220, 9'd239}) begin
      bad++; $display("FAIL accel_restart: got %h want %h", c_if.paddle_y, {9'd220, 9'd239});
    end
  endtask

  task automatic test_reset_mid_req();
    ack_delay = 1000;
    tick_a(2'b01, 2'b00);
    for (int k = 0; k < 20 && a_if.upd_req !== 1'b1; k++) @(negedge clk);
    total++;
    if (a_if.upd_req !== 1'b1) begin
      bad++; $display("FAIL midreq_no_req: got %b want 1", a_if.upd_req);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reset_models();
    exp_q.delete();
    ack_delay = 0;
    total++;
    if (a_if.upd_req !== 1'b0 || a_if.busy !== 1'b0 || a_if.moved !== 2'b00 || a_if.upd_idx !== 1'b0) begin
      bad++;
      $display("FAIL midreq_reset_ctrl: got req=%b busy=%b moved=%b idx=%0d want 0 0 00 0",
               a_if.upd_req, a_if.busy, a_if.moved, a_if.upd_idx);
    end
    total++;
    if (a_if.paddle_y !== pack(ma_y) || a_if.old_paddle_y !== pack(ma_old)) begin
      bad++; $display("FAIL midreq_reset_y: got %h/%h want %h", a_if.paddle_y, a_if.old_paddle_y, pack(ma_y));
    end
    tick_a(2'b00, 2'b10);
    wait_idle_a();
    total++;
    if (busy_cycles !== N + 1 || exp_q.size() !== 0) begin
      bad++; $display("FAIL after_reset_seq: got busy %0d left %0d want %0d left 0", busy_cycles, exp_q.size(), N + 1);
    end
  endtask

  initial begin
    a_if.enable = 1'b1; a_if.frame_tick = 1'b0; a_if.up = '0; a_if.down = '0;
    b_if.enable = 1'b1; b_if.frame_tick = 1'b0; b_if.up = '0; b_if.down = '0;
    c_if.enable = 1'b1; c_if.frame_tick = 1'b0; c_if.up = '0; c_if.down = '0;
    test_reset();
    test_single_up();
    test_both_delay();
    test_stop_and_disabled();
    test_clamp();
    test_accel();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
